reg_read_stage: RTL and testbench
=================================

Name: reg_read_stage

Overview:
- Operand capture stage directly downstream of the register banks.
- Samples the combinational bank read data in the cycle the read is enabled, with same-cycle write-to-read bypass.
- Holds the operand bundles in a small FIFO and presents them to the PE tree input crossbar with a valid/ready handshake.
- Asserts stall_req upstream when it cannot accept more bundles.

Parameters:
- N_BANKS, 32, number of register banks / operand lanes (from common_pkg)
- BANK_DEPTH, 32, entries per bank; ADDR_W = $clog2(BANK_DEPTH)
- WORD_W, 32, data word width (word_t)
- FIFO_DEPTH, 2, operand bundles buffered; legal values 2..8
- BYPASS_EN, 1, 1 = forward same-cycle write data to a matching read

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pipe_en  in  1  global pipeline enable
- reg_re  in  N_BANKS  per-bank read enable
- reg_rd_addr  in  N_BANKS*ADDR_W  per-bank read address
- bank_rd_data  in  N_BANKS*WORD_W  combinational bank outputs
- reg_we  in  N_BANKS  per-bank write enable, same cycle
- reg_wr_addr  in  N_BANKS*ADDR_W  per-bank write address, from invalid-state tracker
- reg_wr_data  in  N_BANKS*WORD_W  per-bank write data
- out_valid  out  1  head bundle valid
- out_ready  in  1  consumer accepts head bundle
- out_mask  out  N_BANKS  lanes carrying an operand in head bundle
- out_data  out  N_BANKS*WORD_W  head bundle operands
- stall_req  out  1  FIFO full; upstream must hold pipe_en low
- overflow  out  1  sticky error; a push was dropped

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, rd/wr pointers=0, out_valid=0, out_mask=0, out_data=0, stall_req=0, overflow=0.
  - FIFO contents need not be cleared.
  - Reset mid-operation discards all buffered bundles.
- Push condition: pipe_en & (|reg_re).
- Lane capture value for lane i:
  - bypass_i = BYPASS_EN & reg_re[i] & reg_we[i] & (reg_rd_addr[i]==reg_wr_addr[i]).
  - data_i = bypass_i ? reg_wr_data[i] : bank_rd_data[i].
  - Lanes with reg_re[i]=0 store 0.
  - mask = reg_re.
- Pop condition: out_valid & out_ready.
- Outputs out_valid, out_mask and out_data come from registered FIFO head state.
  - Latency is 1 cycle: push at cycle N gives out_valid=1 at N+1 when the FIFO was empty.
  - No combinational path from reg_* to out_*.
- When out_valid=0: out_mask=0 and out_data=0, driven explicitly.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push & pop together: unchanged, always legal including when full.
  - Pointers wrap modulo FIFO_DEPTH.
- stall_req is registered and equals (next count == FIFO_DEPTH).
  - Upstream sees it one cycle after the filling push.
  - With FIFO_DEPTH>=2 this never causes a drop provided upstream honours it.
- Push while count==FIFO_DEPTH with no pop:
  - Bundle dropped, FIFO unchanged, overflow<=1.
  - overflow clears only on rst.
- pipe_en=0: no push, regardless of reg_re; pops continue.
- reg_re=0 with pipe_en=1: no push, so no empty bundles are created.
- Out_ready while out_valid=0: ignored.
- Handshake rules:
  - out_mask and out_data stay stable while out_valid=1 and out_ready=0.
  - The consumer may assert out_ready unconditionally.
- Unknown inputs are not filtered. A VERIFICATION-only assertion flags X on reg_re or pipe_en after reset.

Decomposition:
- Shared package (instr_decd_pkg / common_pkg):
  - ADDR_W, word_t, and reg_rd_addr_t (already exist there).
  - New typedef operand_bundle_t {logic [N_BANKS-1:0] mask; word_t [N_BANKS-1:0] data}.
  - Localparam RD_FIFO_DEPTH.
- One sub-module: operand_fifo.
  - Parameterised on the bundle type and depth.
  - Owns the pointers, count, full/empty state and the overflow flag.
- reg_read_stage itself contains only the bypass/capture logic and the registered stall.

Test Plan:
- Basic read: after reset, pipe_en=1, reg_re=0x1, rd_addr[0]=3, bank_rd_data[0]=0xA5A5 for one cycle, out_ready=1 → next cycle out_valid=1, out_mask=0x1, out_data[0]=0xA5A5, all other lanes 0; the cycle after, out_valid=0.
- Bypass: reg_re[2]=1, rd_addr[2]=5, reg_we[2]=1, wr_addr[2]=5, wr_data=0x1234, bank_rd_data[2]=0xDEAD → out_data[2]=0x1234. Repeat with wr_addr=6 → 0xDEAD. Repeat with BYPASS_EN=0 → 0xDEAD.
- Backpressure: out_ready=0, push 2 bundles (0x11, 0x22 on lane 1) → stall_req=1 one cycle after the second push; head holds 0x11 stable. Raise out_ready → 0x11 then 0x22 in order; stall_req drops after the first pop.
- Simultaneous push/pop at full: FIFO full, out_ready=1 and push 0x33 in the same cycle → count stays 2, overflow=0, outputs sequence 0x22, 0x33.
- Overflow: full, out_ready=0, force push (pipe_en=1 ignoring stall_req) → overflow=1 sticky, FIFO contents unchanged; rst → overflow=0, out_valid=0.
- Stall gating: pipe_en=0 with reg_re=0xFFFFFFFF for 5 cycles → no push, out_valid stays 0. Reset asserted with 1 bundle buffered → out_valid=0 on the next cycle.

Source files
------------

// File: rtl/reg_read_stage_pkg.sv
// ---------------------------------------------------------------------------
// reg_read_stage_pkg
//   Shared types and sizes for the operand read stage that sits between the
//   register banks and the PE tree input crossbar.
//   - N_BANKS / BANK_DEPTH / WORD_W : bank geometry
//   - ADDR_W                        : per-bank address width
//   - RD_FIFO_DEPTH                 : default depth of the operand FIFO
//   - operand_bundle_t              : one captured bundle (lane mask + data)
// ---------------------------------------------------------------------------
package reg_read_stage_pkg;

  localparam int N_BANKS       = 32;
  localparam int BANK_DEPTH    = 32;
  localparam int ADDR_W        = $clog2(BANK_DEPTH);
  localparam int WORD_W        = 32;
  localparam int RD_FIFO_DEPTH = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_rd_addr_t;

  typedef struct packed {
    logic [N_BANKS-1:0]  mask;
    word_t [N_BANKS-1:0] data;
  } operand_bundle_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// ---------------------------------------------------------------------------
// reg_read_stage_if
//   Bundles the bank-side read/write signals and the downstream valid/ready
//   operand port of reg_read_stage.
//   modport slave  : the read stage (consumes bank signals, produces operands)
//   modport master : the surrounding pipeline (drives bank signals, consumes)
//   Signals:
//     pipe_en, reg_re, reg_rd_addr, bank_rd_data,
//     reg_we, reg_wr_addr, reg_wr_data            (upstream -> stage)
//     out_valid, out_mask, out_data               (stage -> consumer)
//     out_ready                                   (consumer -> stage)
//     stall_req, overflow                         (stage -> upstream)
// ---------------------------------------------------------------------------
interface reg_read_stage_if;
  import reg_read_stage_pkg::*;

  logic                        pipe_en;
  logic [N_BANKS-1:0]          reg_re;
  reg_rd_addr_t [N_BANKS-1:0]  reg_rd_addr;
  word_t [N_BANKS-1:0]         bank_rd_data;
  logic [N_BANKS-1:0]          reg_we;
  reg_rd_addr_t [N_BANKS-1:0]  reg_wr_addr;
  word_t [N_BANKS-1:0]         reg_wr_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [N_BANKS-1:0]          out_mask;
  word_t [N_BANKS-1:0]         out_data;

  logic                        stall_req;
  logic                        overflow;

  modport slave (
    input  pipe_en, reg_re, reg_rd_addr, bank_rd_data,
    input  reg_we, reg_wr_addr, reg_wr_data,
    input  out_ready,
    output out_valid, out_mask, out_data,
    output stall_req, overflow
  );

  modport master (
    output pipe_en, reg_re, reg_rd_addr, bank_rd_data,
    output reg_we, reg_wr_addr, reg_wr_data,
    output out_ready,
    input  out_valid, out_mask, out_data,
    input  stall_req, overflow
  );

endinterface

// File: rtl/reg_read_stage_operand_fifo.sv
// ---------------------------------------------------------------------------
// operand_fifo
//   Small circular FIFO of operand bundles with a sticky overflow flag.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     push         : request to store push_data
//     push_data    : bundle to store
//     pop          : consumer takes the head (ignored while empty)
//     head_valid   : FIFO holds at least one bundle
//     head_data    : bundle at the read pointer (registered storage)
//     full_next    : count after this cycle's update equals DEPTH
//     overflow     : a push was dropped because the FIFO was full
//   The storage is a handful of wide entries read at the read pointer, so the
//   head is visible the cycle after the push that fills an empty FIFO.
// ---------------------------------------------------------------------------
module operand_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic head_valid,
  output T     head_data,
  output logic full_next,
  output logic overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg;
  logic             full, pop_ok, push_ok, drop;

  // Explicit wrap so non power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == FULL_CNT);
  assign pop_ok  = pop && (count_reg != '0);
  // A simultaneous pop frees the slot, so push+pop is accepted even when full.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Contents are don't-care after reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];
  assign full_next  = (count_next == FULL_CNT);
  assign overflow   = overflow_reg;

endmodule

// File: rtl/reg_read_stage.sv
// ---------------------------------------------------------------------------
// reg_read_stage
//   Captures the combinational register-bank read data for every enabled
//   lane, forwarding same-cycle write data to a matching read, and buffers
//   the resulting operand bundles for the PE tree input crossbar.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     rr       : reg_read_stage_if.slave (bank read/write side, valid/ready
//                operand output, stall_req and overflow status)
//   Parameters:
//     FIFO_DEPTH : bundles buffered (2..8)
//     BYPASS_EN  : 1 = forward reg_wr_data to a read of the same address
// ---------------------------------------------------------------------------
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = RD_FIFO_DEPTH,
  parameter bit BYPASS_EN  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  reg_read_stage_if.slave rr
);

  word_t [N_BANKS-1:0] capture_data;
  operand_bundle_t     capture_bundle;
  operand_bundle_t     head_bundle;
  logic                push, pop, head_valid, full_next, fifo_overflow;
  logic                stall_req_reg;

  // Per-lane capture: a write to the address being read this cycle wins over
  // the (stale) bank output; disabled lanes store zero.
  generate
    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_lane
      logic bypass;
      assign bypass = BYPASS_EN && rr.reg_re[gi] && rr.reg_we[gi] &&
                      (rr.reg_rd_addr[gi] == rr.reg_wr_addr[gi]);
      assign capture_data[gi] = !rr.reg_re[gi] ? '0 :
                                (bypass ? rr.reg_wr_data[gi] : rr.bank_rd_data[gi]);
    end
  endgenerate

  assign capture_bundle.mask = rr.reg_re;
  assign capture_bundle.data = capture_data;

  // Empty bundles are never created.
  assign push = rr.pipe_en && (|rr.reg_re);
  assign pop  = head_valid && rr.out_ready;

  operand_fifo #(
    .T     (operand_bundle_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (capture_bundle),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_bundle),
    .full_next  (full_next),
    .overflow   (fifo_overflow)
  );

  // Registered so upstream sees it the cycle after the filling push.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_req_reg <= 1'b0;
    end else begin
      stall_req_reg <= full_next;
    end
  end

  assign rr.out_valid = head_valid;
  assign rr.out_mask  = head_valid ? head_bundle.mask : '0;
  assign rr.out_data  = head_valid ? head_bundle.data : '0;
  assign rr.stall_req = stall_req_reg;
  assign rr.overflow  = fifo_overflow;

`ifndef SYNTHESIS
  // Control inputs must be known once out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_ctrl_known: assert (!$isunknown({rr.pipe_en, rr.reg_re}));
    end
  end
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_read_stage_if if0 ();
  reg_read_stage_if if1 ();

  reg_read_stage #(.FIFO_DEPTH(RD_FIFO_DEPTH), .BYPASS_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .rr  (if0.slave)
  );

  reg_read_stage #(.FIFO_DEPTH(RD_FIFO_DEPTH), .BYPASS_EN(1'b0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .rr  (if1.slave)
  );

  // The no-bypass instance sees exactly the same stimulus.
  assign if1.pipe_en      = if0.pipe_en;
  assign if1.reg_re       = if0.reg_re;
  assign if1.reg_rd_addr  = if0.reg_rd_addr;
  assign if1.bank_rd_data = if0.bank_rd_data;
  assign if1.reg_we       = if0.reg_we;
  assign if1.reg_wr_addr  = if0.reg_wr_addr;
  assign if1.reg_wr_data  = if0.reg_wr_data;
  assign if1.out_ready    = if0.out_ready;

  typedef struct {
    bit           r;
    bit           pe;
    logic [31:0]  re;
    logic [31:0]  we;
    reg_rd_addr_t ra;
    reg_rd_addr_t wa;
    logic [31:0]  rdb;
    logic [31:0]  wrb;
    bit           rdy;
    bit           ev;
    logic [31:0]  em;
    int           el;
    logic [31:0]  ed;
    logic [31:0]  ednb;
    bit           es;
    bit           eo;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(bit r, bit pe, logic [31:0] re, logic [31:0] we,
                              reg_rd_addr_t ra, reg_rd_addr_t wa,
                              logic [31:0] rdb, logic [31:0] wrb, bit rdy,
                              bit ev, logic [31:0] em, int el,
                              logic [31:0] ed, logic [31:0] ednb, bit es, bit eo);
    vec_t v;
    v.r = r; v.pe = pe; v.re = re; v.we = we; v.ra = ra; v.wa = wa;
    v.rdb = rdb; v.wrb = wrb; v.rdy = rdy; v.ev = ev; v.em = em; v.el = el;
    v.ed = ed; v.ednb = ednb; v.es = es; v.eo = eo;
    return v;
  endfunction

  function automatic vec_t idle(bit rdy, bit ev, logic [31:0] em, int el,
                                logic [31:0] ed, bit es, bit eo);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, rdy, ev, em, el, ed, ed, es, eo);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Whole-bundle check: only lane el may be non-zero.
  task automatic chk_lanes(string name, word_t [N_BANKS-1:0] act, int el, logic [31:0] ed);
    int bad_lane;
    logic [31:0] exp;
    bad_lane = -1;
    for (int i = 0; i < N_BANKS; i++) begin
      exp = (i == el) ? ed : 32'h0;
      if (act[i] !== exp && bad_lane < 0) bad_lane = i;
    end
    n_cmp++;
    if (bad_lane >= 0) begin
      n_bad++;
      exp = (bad_lane == el) ? ed : 32'h0;
      $display("FAIL %s lane %0d: got 0x%08h expected 0x%08h", name, bad_lane, act[bad_lane], exp);
    end
  endtask

  task automatic drive(bit r, bit pe, logic [31:0] re, logic [31:0] we,
                       reg_rd_addr_t ra, reg_rd_addr_t wa,
                       logic [31:0] rdb, logic [31:0] wrb, bit rdy);
    rst           = r;
    if0.pipe_en   = pe;
    if0.reg_re    = re;
    if0.reg_we    = we;
    if0.out_ready = rdy;
    for (int i = 0; i < N_BANKS; i++) begin
      if0.reg_rd_addr[i]  = ra;
      if0.reg_wr_addr[i]  = wa;
      if0.bank_rd_data[i] = rdb + 32'(i);
      if0.reg_wr_data[i]  = wrb + 32'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic read, no-push cases, bypass on/off
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 3, 0, 32'hA5A5, 0, 1,  1, 1, 0, 32'hA5A5, 32'hA5A5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 0, 32'hA5A5, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 4, 5, 5, 32'hDEAB, 32'h1232, 1,  1, 4, 2, 32'h1234, 32'hDEAD, 0, 0));
    vecs.push_back(mk(0, 1, 4, 4, 5, 6, 32'hDEAB, 32'h1232, 1,  1, 4, 2, 32'hDEAD, 32'hDEAD, 0, 0));
    vecs.push_back(idle(1,  0, 0, 2, 0, 0, 0));
    // Backpressure
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h10, 0, 0,  1, 2, 1, 32'h11, 32'h11, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h21, 0, 0,  1, 2, 1, 32'h11, 32'h11, 1, 0));
    vecs.push_back(idle(0,  1, 2, 1, 32'h11, 1, 0));
    vecs.push_back(idle(1,  1, 2, 1, 32'h22, 0, 0));
    vecs.push_back(idle(0,  1, 2, 1, 32'h22, 0, 0));
    // Push and pop together while full
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h32, 0, 0,  1, 2, 1, 32'h22, 32'h22, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h43, 0, 1,  1, 2, 1, 32'h33, 32'h33, 1, 0));
    vecs.push_back(idle(1,  1, 2, 1, 32'h44, 0, 0));
    // Overflow: forced push while full is dropped, flag is sticky until reset
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h54, 0, 0,  1, 2, 1, 32'h44, 32'h44, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 32'h65, 0, 0,  1, 2, 1, 32'h44, 32'h44, 1, 1));
    vecs.push_back(idle(1,  1, 2, 1, 32'h55, 0, 1));
    vecs.push_back(idle(1,  0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // pipe_en low blocks pushes
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 32'h77, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // Reset with one bundle buffered
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h80, 0, 0,  1, 1, 0, 32'h80, 32'h80, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[n]) begin
      vec_t v;
      v = vecs[n];
      drive(v.r, v.pe, v.re, v.we, v.ra, v.wa, v.rdb, v.wrb, v.rdy);
      tick();
      $display("vec %0d: rst=%0b pe=%0b re=%08h rdy=%0b -> valid=%0b mask=%08h lane%0d=%08h nb=%08h stall=%0b ovf=%0b",
               n, v.r, v.pe, v.re, v.rdy, if0.out_valid, if0.out_mask, v.el,
               if0.out_data[v.el], if1.out_data[v.el], if0.stall_req, if0.overflow);
      chk("out_valid", 32'(if0.out_valid), 32'(v.ev));
      chk("out_mask", if0.out_mask, v.em);
      chk_lanes("out_data", if0.out_data, v.el, v.ed);
      chk_lanes("out_data_nobypass", if1.out_data, v.el, v.ednb);
      chk("stall_req", 32'(if0.stall_req), 32'(v.es));
      chk("overflow", 32'(if0.overflow), 32'(v.eo));
    end

    // All-lane bundle with bypass on lane 7 only, then held under backpressure
    drive(0, 1, 32'hFFFF_FFFF, 32'h0000_0080, 9, 9, 32'h1000, 32'h2000, 0);
    tick();
    $display("seq all-lanes: valid=%0b mask=%08h lane7=%08h lane31=%08h", if0.out_valid, if0.out_mask, if0.out_data[7], if0.out_data[31]);
    chk("all_mask", if0.out_mask, 32'hFFFF_FFFF);
    for (int i = 0; i < N_BANKS; i++) begin
      chk($sformatf("all_lane%0d", i), if0.out_data[i], (i == 7) ? 32'h2007 : 32'h1000 + 32'(i));
    end
    chk("all_lane7_nobypass", if1.out_data[7], 32'h1007);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      $display("seq hold %0d: valid=%0b lane7=%08h lane31=%08h", k, if0.out_valid, if0.out_data[7], if0.out_data[31]);
      chk("hold_valid", 32'(if0.out_valid), 32'd1);
      chk("hold_lane7", if0.out_data[7], 32'h2007);
      chk("hold_lane31", if0.out_data[31], 32'h101F);
      chk("hold_stall", 32'(if0.stall_req), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    $display("seq drain: valid=%0b mask=%08h", if0.out_valid, if0.out_mask);
    chk("drain_valid", 32'(if0.out_valid), 32'd0);
    chk("drain_mask", if0.out_mask, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
